// File: rtl/weight_stream_gen_pkg.sv
// Shared layer constants, FSM state codes and width helpers for the weight streamer.
package weight_stream_gen_pkg;

  localparam int unsigned coeff_width       = 16;
  localparam int unsigned kern_s_conv_0     = 288;
  localparam int unsigned repeat_s_conv_0   = 1;
  localparam int unsigned buf_depth_default = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom.sv
// Coefficient ROM with a registered read port (latency 1); contents supplied by the system loader.
module rom #(
  parameter int unsigned W        = 16,
  parameter int unsigned DEPTH    = 288,
  parameter int unsigned AW       = 9,
  parameter string       MEM_FILE = ""
) (
  input  logic          clk,
  input  logic          ce,
  input  logic [AW-1:0] addr,
  output logic [W-1:0]  q
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ce) q_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/weight_stream_gen_prefetch_buf.sv
// Small synchronous FIFO holding {last, word} entries between the ROM and the output port.
module weight_prefetch_buf #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/weight_stream_gen.sv
// Streams one layer's coefficients from ROM into its FIFO, REPEAT passes per start,
// with a credit-limited prefetch buffer so the stream runs at one word per cycle.
module weight_stream_gen
  import weight_stream_gen_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = coeff_width,
  parameter int unsigned KERN_SIZE   = kern_s_conv_0,
  parameter int unsigned REPEAT      = repeat_s_conv_0,
  parameter int unsigned BUF_DEPTH   = buf_depth_default,
  parameter string       MEM_FILE    = "./conv_0_weight.mem"
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   start,
  output logic                   idle,
  output logic                   done,
  output logic [COEFF_WIDTH-1:0] output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write,
  output logic                   output_V_last
);

  localparam int unsigned AW = clog2_min1(KERN_SIZE);
  localparam int unsigned PW = clog2_min1(REPEAT + 1);
  localparam int unsigned OW = $clog2(BUF_DEPTH) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(KERN_SIZE - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'((REPEAT == 0) ? 0 : REPEAT - 1);
  localparam logic [OW-1:0] CREDIT    = OW'(BUF_DEPTH);

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [PW-1:0]          pass_q, pass_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   rd_last_q, rd_last_d;
  logic                   idle_q, idle_d;
  logic                   done_q, done_d;

  logic                   issue_c;
  logic                   issue_last_c;
  logic                   pop_c;
  logic [COEFF_WIDTH-1:0] rom_q;
  logic [COEFF_WIDTH:0]   buf_head;
  logic [OW-1:0]          buf_count;
  logic                   buf_empty;

  // Words already requested but not yet buffered count against the buffer space.
  assign issue_c      = (state_q == ST_RUN) && ((buf_count + OW'(rd_vld_q)) < CREDIT);
  assign issue_last_c = issue_c && (addr_q == LAST_ADDR);
  assign pop_c        = !buf_empty && output_V_full_n;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    idle_d    = idle_q;
    done_d    = 1'b0;
    rd_vld_d  = issue_c;
    rd_last_d = issue_last_c;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = '0;
          pass_d  = '0;
          idle_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (issue_last_c) begin
          addr_d = '0;
          if (REPEAT != 0) begin
            if (pass_q == LAST_PASS) state_d = ST_DRAIN;
            else                     pass_d  = pass_q + PW'(1);
          end
        end else if (issue_c) begin
          addr_d = addr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        // Finish when the word being popped now is the last one anywhere in the pipe.
        if (!rd_vld_q && (buf_count == OW'(pop_c))) begin
          state_d = ST_IDLE;
          idle_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      pass_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
    end
  end

  rom #(
    .W        (COEFF_WIDTH),
    .DEPTH    (KERN_SIZE),
    .AW       (AW),
    .MEM_FILE (MEM_FILE)
  ) u_rom (
    .clk  (ap_clk),
    .ce   (issue_c),
    .addr (addr_q),
    .q    (rom_q)
  );

  weight_prefetch_buf #(
    .WIDTH (COEFF_WIDTH + 1),
    .DEPTH (BUF_DEPTH),
    .CW    (OW)
  ) u_buf (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (rd_vld_q),
    .din   ({rd_last_q, rom_q}),
    .pop   (pop_c),
    .dout  (buf_head),
    .count (buf_count),
    .empty (buf_empty)
  );

  assign idle           = idle_q;
  assign done           = done_q;
  assign output_V_write = pop_c;
  assign output_V_din   = buf_head[COEFF_WIDTH-1:0];
  assign output_V_last  = buf_head[COEFF_WIDTH];

endmodule
